// File: rtl/isram_axi_pkg.sv
// Shared definitions for the instruction-side SRAM slave: response codes, FSM encodings, reset PC.
// ISRAM_RAND_DELAY_EN selects the randomised-latency variant in isram_axi.
package isram_axi_pkg;

    localparam logic [31:0] RST_PC = 32'h8000_0000;

    localparam logic [2:0] RESP_OKAY   = 3'b000;
    localparam logic [2:0] RESP_SLVERR = 3'b010;
    localparam logic [2:0] RESP_DECERR = 3'b011;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        RESP = 2'b11
    } state_t;

    localparam logic [7:0] LFSR_SEED = 8'h01;

endpackage

// File: rtl/isram_lfsr.sv
// 8-bit Fibonacci LFSR (taps 8,6,5,4) that steps once per enable; used for fetch-latency jitter
// when ISRAM_RAND_DELAY_EN is defined.
module isram_lfsr
    import isram_axi_pkg::*;
#(
    parameter logic [7:0] SEED = LFSR_SEED
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    output logic [7:0] q
);

    logic fb;

    assign fb = q[7] ^ q[5] ^ q[4] ^ q[3];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= SEED;
        end else if (en) begin
            q <= {q[6:0], fb};
        end
    end

endmodule

// File: rtl/isram_axi.sv
// Read-only AXI-lite instruction SRAM with programmable wait states, error responses and a preload port.
// Define ISRAM_RAND_DELAY_EN to add LFSR-driven extra latency per fetch.
module isram_axi
    import isram_axi_pkg::*;
#(
    parameter int                  DATA_LEN  = 32,
    parameter int                  DEPTH     = 1024,
    parameter logic [DATA_LEN-1:0] BASE_ADDR = DATA_LEN'(RST_PC),
    parameter int                  LATENCY   = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                arvalid,
    output logic                arready,
    input  logic [DATA_LEN-1:0] araddr,
    output logic [DATA_LEN-1:0] rdata,
    output logic                rvalid,
    output logic [2:0]          rresp,
    input  logic                rready,
    input  logic                ld_wen,
    input  logic [DATA_LEN-1:0] ld_addr,
    input  logic [DATA_LEN-1:0] ld_wdata
);

    localparam int                  IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int                  CNT_W   = 5;
    localparam logic [DATA_LEN-1:0] DEPTH_W = DATA_LEN'(DEPTH);

    logic [DATA_LEN-1:0] mem [DEPTH];

    state_t            state_reg, state_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic [2:0]        cls_reg, cls_next;
    logic [IDX_W-1:0]  idx_reg, idx_next;
    logic              arready_next, rvalid_next;
    logic [2:0]        rresp_next;
    logic              rdata_load, rdata_clear;
    logic              accept;
    logic [CNT_W-1:0]  delay;

    // Addresses below BASE_ADDR wrap to huge word offsets and so fall into DECERR.
    function automatic logic [2:0] classify(input logic [DATA_LEN-1:0] addr);
        logic [DATA_LEN-1:0] word;
        word = (addr - BASE_ADDR) >> 2;
        if (addr[1:0] != 2'b00) return RESP_SLVERR;
        if (word >= DEPTH_W)    return RESP_DECERR;
        return RESP_OKAY;
    endfunction

    function automatic logic [IDX_W-1:0] word_index(input logic [DATA_LEN-1:0] addr);
        logic [DATA_LEN-1:0] word;
        word = (addr - BASE_ADDR) >> 2;
        return word[IDX_W-1:0];
    endfunction

    assign accept = (state_reg == IDLE) && arvalid && arready;

`ifdef ISRAM_RAND_DELAY_EN
    logic [7:0] lfsr_q;

    isram_lfsr #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk (clk),
        .rst (rst),
        .en  (accept),
        .q   (lfsr_q)
    );

    assign delay = CNT_W'(LATENCY) + CNT_W'(lfsr_q[3:0]);
`else
    assign delay = CNT_W'(LATENCY);
`endif

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        cls_next     = cls_reg;
        idx_next     = idx_reg;
        arready_next = arready;
        rvalid_next  = rvalid;
        rresp_next   = rresp;
        rdata_load   = 1'b0;
        rdata_clear  = 1'b0;
        case (state_reg)
            IDLE: begin
                arready_next = 1'b1;
                if (accept) begin
                    arready_next = 1'b0;
                    cls_next     = classify(araddr);
                    idx_next     = word_index(araddr);
                    cnt_next     = delay;
                    state_next   = (delay == '0) ? RESP : WAIT;
                end
            end
            WAIT: begin
                cnt_next = cnt_reg - CNT_W'(1);
                if (cnt_reg <= CNT_W'(1)) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                // First RESP cycle loads the response; afterwards hold it until the handshake.
                if (!rvalid) begin
                    rvalid_next = 1'b1;
                    rresp_next  = cls_reg;
                    rdata_load  = 1'b1;
                end else if (rready) begin
                    rvalid_next  = 1'b0;
                    arready_next = 1'b1;
                    state_next   = IDLE;
                end
            end
            default: begin
                state_next   = IDLE;
                cnt_next     = '0;
                arready_next = 1'b0;
                rvalid_next  = 1'b0;
                rresp_next   = RESP_OKAY;
                rdata_clear  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            cls_reg   <= RESP_OKAY;
            idx_reg   <= '0;
            arready   <= 1'b0;
            rvalid    <= 1'b0;
            rresp     <= RESP_OKAY;
            rdata     <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            cls_reg   <= cls_next;
            idx_reg   <= idx_next;
            arready   <= arready_next;
            rvalid    <= rvalid_next;
            rresp     <= rresp_next;
            if (rdata_clear) begin
                rdata <= '0;
            end else if (rdata_load) begin
                rdata <= (cls_reg == RESP_OKAY) ? mem[idx_reg] : '0;
            end
        end
    end

    // Preload port: same decode as reads, bad addresses are silently dropped.
    always_ff @(posedge clk) begin
        if (ld_wen && (classify(ld_addr) == RESP_OKAY)) begin
            mem[word_index(ld_addr)] <= ld_wdata;
        end
    end

endmodule

// File: tb/tb_isram_axi.sv
// Self-checking bench for isram_axi: three instances at LATENCY 1, 0 and 4 driven by directed vectors.
// Under ISRAM_RAND_DELAY_EN the expected latencies follow a reference LFSR seeded with 8'h01.
`timescale 1ns/1ps
module tb_isram_axi;
    import isram_axi_pkg::*;

    localparam int NI = 3;
    localparam int LAT [NI] = '{1, 0, 4};
    localparam logic [31:0] BASE = 32'h8000_0000;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [2:0]  resp;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_s      [NI];
    logic        arvalid_s  [NI];
    logic        arready_s  [NI];
    logic [31:0] araddr_s   [NI];
    logic [31:0] rdata_s    [NI];
    logic        rvalid_s   [NI];
    logic [2:0]  rresp_s    [NI];
    logic        rready_s   [NI];
    logic        ld_wen_s   [NI];
    logic [31:0] ld_addr_s  [NI];
    logic [31:0] ld_wdata_s [NI];

    logic [7:0]  lfsr_m [NI];
    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < NI; gi++) begin : g_dut
        isram_axi #(
            .DATA_LEN  (32),
            .DEPTH     (1024),
            .BASE_ADDR (BASE),
            .LATENCY   (LAT[gi])
        ) u_dut (
            .clk      (clk),
            .rst      (rst_s[gi]),
            .arvalid  (arvalid_s[gi]),
            .arready  (arready_s[gi]),
            .araddr   (araddr_s[gi]),
            .rdata    (rdata_s[gi]),
            .rvalid   (rvalid_s[gi]),
            .rresp    (rresp_s[gi]),
            .rready   (rready_s[gi]),
            .ld_wen   (ld_wen_s[gi]),
            .ld_addr  (ld_addr_s[gi]),
            .ld_wdata (ld_wdata_s[gi])
        );
    end

    function automatic logic [31:0] img(input int w);
        return (w == 0) ? 32'h0000_0413 : (32'hC0DE_0000 | 32'(w));
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h required %h", name, got, exp);
    endtask

    task automatic next_delay(input int i, output int d);
`ifdef ISRAM_RAND_DELAY_EN
        d = LAT[i] + int'(lfsr_m[i][3:0]);
        lfsr_m[i] = {lfsr_m[i][6:0], lfsr_m[i][7] ^ lfsr_m[i][5] ^ lfsr_m[i][4] ^ lfsr_m[i][3]};
`else
        d = LAT[i];
`endif
    endtask

    // Called and returns on a negative edge.
    task automatic preload(input int i, input logic [31:0] addr, input logic [31:0] data);
        ld_wen_s[i]   = 1'b1;
        ld_addr_s[i]  = addr;
        ld_wdata_s[i] = data;
        @(negedge clk);
        ld_wen_s[i]   = 1'b0;
    endtask

    // One read transaction; latency counted in cycles from the address handshake edge.
    task automatic fetch(input int i, input logic [31:0] addr, input logic [31:0] exp_data,
                         input logic [2:0] exp_resp, input bit keep, input string tag);
        int guard;
        int lat;
        int d;
        araddr_s[i]  = addr;
        arvalid_s[i] = 1'b1;
        guard = 0;
        while (!arready_s[i] && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check({tag, " arready"}, 32'(arready_s[i]), 32'd1);
        if (!arready_s[i]) begin
            arvalid_s[i] = 1'b0;
            return;
        end
        next_delay(i, d);
        @(negedge clk);
        if (!keep) arvalid_s[i] = 1'b0;
        check({tag, " arready_drop"}, 32'(arready_s[i]), 32'd0);
        lat = 0;
        while (!rvalid_s[i] && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check({tag, " rvalid"},  32'(rvalid_s[i]), 32'd1);
        check({tag, " latency"}, 32'(lat), 32'(d + 1));
        check({tag, " rdata"},   rdata_s[i], exp_data);
        check({tag, " rresp"},   32'(rresp_s[i]), 32'(exp_resp));
        check({tag, " arready_busy"}, 32'(arready_s[i]), 32'd0);
        if (rready_s[i]) begin
            @(negedge clk);
            check({tag, " rvalid_clr"}, 32'(rvalid_s[i]), 32'd0);
            check({tag, " arready_ret"}, 32'(arready_s[i]), 32'd1);
        end
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs [9];
        int   seen;
        int   guard;

        vecs[0] = '{BASE,                 img(0),    RESP_OKAY};
        vecs[1] = '{BASE + 32'h4,         img(1),    RESP_OKAY};
        vecs[2] = '{BASE + 32'h2,         32'h0,     RESP_SLVERR};
        vecs[3] = '{BASE + 32'h1000,      32'h0,     RESP_DECERR};
        vecs[4] = '{32'h7FFF_FFFC,        32'h0,     RESP_DECERR};
        vecs[5] = '{BASE + 32'hFFC,       img(1023), RESP_OKAY};
        vecs[6] = '{BASE + 32'h1001,      32'h0,     RESP_SLVERR};
        vecs[7] = '{32'h0000_0000,        32'h0,     RESP_DECERR};
        vecs[8] = '{BASE + 32'h1C,        img(7),    RESP_OKAY};

        for (int i = 0; i < NI; i++) begin
            rst_s[i] = 1'b1;  arvalid_s[i] = 1'b0; araddr_s[i] = '0; rready_s[i] = 1'b1;
            ld_wen_s[i] = 1'b0; ld_addr_s[i] = '0; ld_wdata_s[i] = '0; lfsr_m[i] = 8'h01;
        end
        repeat (2) @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            check($sformatf("rst%0d arready", i), 32'(arready_s[i]), 32'd0);
            check($sformatf("rst%0d rvalid", i),  32'(rvalid_s[i]),  32'd0);
            check($sformatf("rst%0d rdata", i),   rdata_s[i],        32'd0);
            check($sformatf("rst%0d rresp", i),   32'(rresp_s[i]),   32'd0);
        end

        // Preload image (array writes are not blocked by reset), then try writes that must drop.
        for (int i = 0; i < NI; i++) begin
            for (int w = 0; w < 8; w++) preload(i, BASE + 32'(4 * w), img(w));
            preload(i, BASE + 32'hFFC, img(1023));
        end
        preload(0, BASE + 32'h1000, 32'hDEAD_0000);
        preload(0, BASE + 32'h6,    32'hBEEF_0000);
        preload(0, 32'h7FFF_FFFC,   32'hBAD0_0000);

        for (int i = 0; i < NI; i++) rst_s[i] = 1'b0;
        check("release arready0", 32'(arready_s[0]), 32'd0);
        @(negedge clk);
        for (int i = 0; i < NI; i++)
            check($sformatf("first_cycle%0d arready", i), 32'(arready_s[i]), 32'd1);

        for (int v = 0; v < 9; v++)
            fetch(0, vecs[v].addr, vecs[v].data, vecs[v].resp, 1'b0, $sformatf("vec%0d", v));

        // Backpressure on instance 0.
        rready_s[0] = 1'b0;
        fetch(0, BASE + 32'h8, img(2), RESP_OKAY, 1'b0, "bp");
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check($sformatf("bp%0d rvalid", k),  32'(rvalid_s[0]),  32'd1);
            check($sformatf("bp%0d rdata", k),   rdata_s[0],        img(2));
            check($sformatf("bp%0d rresp", k),   32'(rresp_s[0]),   32'(RESP_OKAY));
            check($sformatf("bp%0d arready", k), 32'(arready_s[0]), 32'd0);
        end
        rready_s[0] = 1'b1;
        @(negedge clk);
        check("bp_done rvalid",  32'(rvalid_s[0]),  32'd0);
        check("bp_done arready", 32'(arready_s[0]), 32'd1);
        @(negedge clk);
        check("bp_single rvalid", 32'(rvalid_s[0]), 32'd0);

        // LATENCY=0 back-to-back, arvalid held high across transactions.
        for (int w = 0; w < 8; w++)
            fetch(1, BASE + 32'(4 * w), img(w), RESP_OKAY, 1'b1, $sformatf("b2b%0d", w));
        arvalid_s[1] = 1'b0;
        @(negedge clk);

        // Reset during WAIT with LATENCY=4; rdata holds the previous word going in.
        fetch(2, BASE + 32'hC, img(3), RESP_OKAY, 1'b0, "pre_abort");
        araddr_s[2]  = BASE + 32'h10;
        arvalid_s[2] = 1'b1;
        guard = 0;
        while (!arready_s[2] && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        @(negedge clk);
        arvalid_s[2] = 1'b0;
        @(negedge clk);
        rst_s[2] = 1'b1;
        #1;
        check("abort arready", 32'(arready_s[2]), 32'd0);
        check("abort rvalid",  32'(rvalid_s[2]),  32'd0);
        check("abort rdata",   rdata_s[2],        32'd0);
        check("abort rresp",   32'(rresp_s[2]),   32'd0);
        lfsr_m[2] = 8'h01;
        @(negedge clk);
        rst_s[2] = 1'b0;
        seen = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (rvalid_s[2]) seen++;
        end
        check("abort no_rvalid", 32'(seen), 32'd0);
        fetch(2, BASE + 32'h14, img(5), RESP_OKAY, 1'b0, "post_abort");

`ifdef ISRAM_RAND_DELAY_EN
        for (int n = 0; n < 256; n++)
            fetch(1, BASE + 32'(4 * (n % 8)), img(n % 8), RESP_OKAY, 1'b0, $sformatf("rand%0d", n));
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
